// File: rtl/pit_tick_irq.sv
// PIT terminal-count to level-interrupt front-end with a four-phase acknowledge,
// saturating missed-tick counter, free-running tick counter and heartbeat LED.
module pit_tick_irq #(
    parameter int LED_DIV    = 8,
    parameter int MISS_WIDTH = 4
) (
    input  logic                  CLOCK,
    input  logic                  RST,
    input  logic                  TICK,
    input  logic                  ENABLE,
    input  logic                  IRQ_ACK,
    input  logic                  MISS_CLR,
    output logic                  IRQ,
    output logic [MISS_WIDTH-1:0] MISSED,
    output logic [7:0]            TICK_COUNT,
    output logic                  LED,
    output logic [1:0]            STATE_DBG
);

    localparam int DIV_W = (LED_DIV > 2) ? $clog2(LED_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(LED_DIV - 1);
    localparam logic [MISS_WIDTH-1:0] MISS_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_tick_q;
    logic                  r_irq;
    logic [MISS_WIDTH-1:0] r_missed;
    logic [7:0]            r_tick_count;
    logic [DIV_W-1:0]      r_div;
    logic                  r_led;

    logic w_edge;
    logic w_en_edge;
    logic w_miss_inc;

    // tick_q resets high so a TICK already high at reset release is not an edge.
    assign w_edge     = TICK & ~r_tick_q;
    assign w_en_edge  = w_edge & ENABLE;
    assign w_miss_inc = w_en_edge & (r_state != IDLE);

    // Four-phase handshake: IRQ rises in PENDING; consumer raises IRQ_ACK
    // (IRQ drops, RELEASE); consumer drops IRQ_ACK (IDLE, ready for next edge).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_en_edge) w_state_nxt = PENDING;
            end
            PENDING: begin
                if (IRQ_ACK)      w_state_nxt = RELEASE;
                else if (!ENABLE) w_state_nxt = IDLE;
            end
            RELEASE: begin
                if (!IRQ_ACK) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_irq    <= 1'b0;
            r_tick_q <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_irq    <= (w_state_nxt == PENDING);
            r_tick_q <= TICK;
        end
    end

    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            r_missed <= '0;
        end else if (MISS_CLR) begin
            r_missed <= w_miss_inc ? MISS_WIDTH'(1) : '0;
        end else if (w_miss_inc && (r_missed != MISS_MAX)) begin
            r_missed <= r_missed + 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            r_tick_count <= '0;
            r_div        <= '0;
            r_led        <= 1'b0;
        end else if (w_en_edge) begin
            r_tick_count <= r_tick_count + 8'd1;
            if (r_div == DIV_LAST) begin
                r_div <= '0;
                r_led <= ~r_led;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign IRQ        = r_irq;
    assign MISSED     = r_missed;
    assign TICK_COUNT = r_tick_count;
    assign LED        = r_led;
    assign STATE_DBG  = r_state;

endmodule

// File: tb/tb_pit_tick_irq.sv
// Directed self-checking bench for pit_tick_irq (LED_DIV = 8, MISS_WIDTH = 4).
module tb_pit_tick_irq;

    logic       CLOCK;
    logic       RST;
    logic       TICK;
    logic       ENABLE;
    logic       IRQ_ACK;
    logic       MISS_CLR;
    logic       IRQ;
    logic [3:0] MISSED;
    logic [7:0] TICK_COUNT;
    logic       LED;
    logic [1:0] STATE_DBG;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    pit_tick_irq #(.LED_DIV(8), .MISS_WIDTH(4)) dut (
        .CLOCK     (CLOCK),
        .RST       (RST),
        .TICK      (TICK),
        .ENABLE    (ENABLE),
        .IRQ_ACK   (IRQ_ACK),
        .MISS_CLR  (MISS_CLR),
        .IRQ       (IRQ),
        .MISSED    (MISSED),
        .TICK_COUNT(TICK_COUNT),
        .LED       (LED),
        .STATE_DBG (STATE_DBG)
    );

    // Clock / reset
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        cyc(2);
        RST = 1'b1;
        cyc(1);
    endtask

    // One-cycle-high TICK pulse followed by one low cycle.
    task automatic pulse();
        TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        cyc(1);
    endtask

    initial begin
        RST = 1'b1; TICK = 1'b0; ENABLE = 1'b1; IRQ_ACK = 1'b0; MISS_CLR = 1'b0;
        #1 RST = 1'b0;
        #1;
        chk("rst_irq", 32'(IRQ), 0);
        chk("rst_missed", 32'(MISSED), 0);
        chk("rst_count", 32'(TICK_COUNT), 0);
        chk("rst_led", 32'(LED), 0);
        chk("rst_state", 32'(STATE_DBG), 32'(ST_IDLE));
        cyc(2);
        RST = 1'b1;
        cyc(1);

        // Single 3-cycle pulse counts once
        TICK = 1'b1;
        cyc(1);
        chk("p1_irq", 32'(IRQ), 1);
        chk("p1_count", 32'(TICK_COUNT), 1);
        cyc(2);
        TICK = 1'b0;
        cyc(1);
        chk("p1_count_hold", 32'(TICK_COUNT), 1);
        chk("p1_state", 32'(STATE_DBG), 32'(ST_PENDING));

        // Handshake
        IRQ_ACK = 1'b1;
        cyc(1);
        chk("hs_irq_low", 32'(IRQ), 0);
        chk("hs_state_rel", 32'(STATE_DBG), 32'(ST_RELEASE));
        cyc(1);
        IRQ_ACK = 1'b0;
        cyc(1);
        chk("hs_state_idle", 32'(STATE_DBG), 32'(ST_IDLE));
        TICK = 1'b1;
        cyc(1);
        chk("hs_irq_again", 32'(IRQ), 1);
        chk("hs_count", 32'(TICK_COUNT), 2);
        chk("hs_missed", 32'(MISSED), 0);
        TICK = 1'b0;
        cyc(1);

        // Missed ticks and saturation
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            pulse();
            if (i == 5) chk("sat_missed5", 32'(MISSED), 4);
        end
        chk("sat_missed", 32'(MISSED), 15);
        chk("sat_count", 32'(TICK_COUNT), 20);
        chk("sat_irq", 32'(IRQ), 1);
        MISS_CLR = 1'b1; TICK = 1'b1;
        cyc(1);
        MISS_CLR = 1'b0; TICK = 1'b0;
        chk("clr_edge_missed", 32'(MISSED), 1);
        chk("clr_edge_count", 32'(TICK_COUNT), 21);
        cyc(1);
        MISS_CLR = 1'b1;
        cyc(1);
        MISS_CLR = 1'b0;
        chk("clr_only_missed", 32'(MISSED), 0);

        // ENABLE gating
        IRQ_ACK = 1'b1;
        cyc(1);
        IRQ_ACK = 1'b0;
        cyc(1);
        ENABLE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse();
            chk("dis_irq", 32'(IRQ), 0);
            chk("dis_count", 32'(TICK_COUNT), 21);
        end
        ENABLE = 1'b1;
        pulse();
        pulse();
        chk("en_irq", 32'(IRQ), 1);
        chk("en_count", 32'(TICK_COUNT), 23);
        chk("en_missed", 32'(MISSED), 1);
        ENABLE = 1'b0; TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        chk("drop_irq", 32'(IRQ), 0);
        chk("drop_state", 32'(STATE_DBG), 32'(ST_IDLE));
        chk("drop_missed", 32'(MISSED), 1);
        chk("drop_count", 32'(TICK_COUNT), 23);
        cyc(1);

        // Edge together with ACK in PENDING; edge together with ACK falling in RELEASE
        ENABLE = 1'b1;
        pulse();
        chk("sim_pend_irq", 32'(IRQ), 1);
        IRQ_ACK = 1'b1; TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        chk("sim_ack_state", 32'(STATE_DBG), 32'(ST_RELEASE));
        chk("sim_ack_missed", 32'(MISSED), 2);
        chk("sim_ack_count", 32'(TICK_COUNT), 25);
        cyc(1);
        IRQ_ACK = 1'b0; TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        chk("sim_rel_state", 32'(STATE_DBG), 32'(ST_IDLE));
        chk("sim_rel_missed", 32'(MISSED), 3);
        chk("sim_rel_count", 32'(TICK_COUNT), 26);
        cyc(1);
        chk("sim_rel_noirq", 32'(IRQ), 0);

        // LED divider and counter wrap
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            TICK = 1'b1;
            cyc(1);
            TICK = 1'b0;
            if (i == 7)  chk("led_e7", 32'(LED), 0);
            if (i == 8)  chk("led_e8", 32'(LED), 1);
            if (i == 15) chk("led_e15", 32'(LED), 1);
            if (i == 16) chk("led_e16", 32'(LED), 0);
            if (i == 24) chk("led_e24", 32'(LED), 1);
            if (i == 200) chk("cnt_e200", 32'(TICK_COUNT), 200);
            cyc(1);
        end
        chk("led_end", 32'(LED), 0);
        chk("cnt_wrap", 32'(TICK_COUNT), 0);
        chk("wrap_missed_sat", 32'(MISSED), 15);

        // Async reset mid-PENDING with TICK held high across release
        do_reset();
        for (int i = 0; i < 3; i++) pulse();
        TICK = 1'b1;
        cyc(1);
        chk("ar_pre_missed", 32'(MISSED), 3);
        chk("ar_pre_irq", 32'(IRQ), 1);
        #2 RST = 1'b0;
        #1;
        chk("ar_irq", 32'(IRQ), 0);
        chk("ar_missed", 32'(MISSED), 0);
        chk("ar_count", 32'(TICK_COUNT), 0);
        chk("ar_led", 32'(LED), 0);
        chk("ar_state", 32'(STATE_DBG), 32'(ST_IDLE));
        cyc(2);
        RST = 1'b1;
        cyc(3);
        chk("ar_held_irq", 32'(IRQ), 0);
        chk("ar_held_count", 32'(TICK_COUNT), 0);
        TICK = 1'b0;
        cyc(1);
        pulse();
        chk("ar_after_irq", 32'(IRQ), 1);
        chk("ar_after_count", 32'(TICK_COUNT), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
